// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and shift-unit mode select for the ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ROR = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Fixed-distance LSL/LSR/ROR datapath with carry-out; purely combinational.
// Zero latency, no flow control.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int LEN   = 32,
  parameter int SHIFT = 2
) (
  input  logic [LEN-1:0] a,
  input  logic [1:0]     mode,
  output logic [LEN-1:0] res,
  output logic           carry
);

  logic [LEN-1:0] lsl_res;
  logic [LEN-1:0] lsr_res;
  logic [LEN-1:0] ror_res;

  always_comb begin
    lsl_res = a << SHIFT;
    lsr_res = a >> SHIFT;
    ror_res = (a >> SHIFT) | (a << (LEN - SHIFT));
    res     = lsl_res;
    carry   = a[LEN-SHIFT];
    case (mode)
      SH_LSR: begin
        res   = lsr_res;
        carry = a[SHIFT-1];
      end
      SH_ROR: begin
        res   = ror_res;
        // rotate carry mirrors the new MSB, i.e. the last bit wrapped around
        carry = ror_res[LEN-1];
      end
      default: begin
        res   = lsl_res;
        carry = a[LEN-SHIFT];
      end
    endcase
  end

endmodule

// File: rtl/alu_main.sv
// Registered ALU: arithmetic, logic and fixed shifts with {N,Z,C,V} flags.
// One-cycle latency, accepts a new operation every cycle, no backpressure.
module alu_main
  import alu_pkg::*;
#(
  parameter int LEN   = 32,
  parameter int SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst,
  output logic [LEN-1:0] response,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [3:0]     opcd,
  output logic [3:0]     flgs
);

  logic [LEN-1:0]   response_q, response_d;
  logic [3:0]       flgs_q, flgs_d;
  logic [LEN:0]     sum;
  logic [LEN:0]     diff;
  logic [2*LEN-1:0] prod;
  logic [LEN-1:0]   res;
  logic             c_bit, v_bit;
  logic [1:0]       sh_mode;
  logic [LEN-1:0]   sh_res;
  logic             sh_carry;

  always_comb begin
    sh_mode = SH_LSL;
    if (opcd == OP_LSR) sh_mode = SH_LSR;
    else if (opcd == OP_ROR) sh_mode = SH_ROR;
  end

  alu_shift_unit #(.LEN(LEN), .SHIFT(SHIFT)) u_shift (
    .a     (a),
    .mode  (sh_mode),
    .res   (sh_res),
    .carry (sh_carry)
  );

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    prod  = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
    res   = a;
    c_bit = 1'b0;
    v_bit = 1'b0;
    case (opcd)
      OP_ADD: begin
        res   = sum[LEN-1:0];
        c_bit = sum[LEN];
        v_bit = (a[LEN-1] == b[LEN-1]) && (res[LEN-1] != a[LEN-1]);
      end
      OP_SUB: begin
        res   = diff[LEN-1:0];
        // diff[LEN] is the borrow, so carry is its complement
        c_bit = ~diff[LEN];
        v_bit = (a[LEN-1] != b[LEN-1]) && (res[LEN-1] != a[LEN-1]);
      end
      OP_MUL: begin
        res   = prod[LEN-1:0];
        c_bit = |prod[2*LEN-1:LEN];
        v_bit = |prod[2*LEN-1:LEN];
      end
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_LSL, OP_LSR, OP_ROR: begin
        res   = sh_res;
        c_bit = sh_carry;
      end
      default: res = a;
    endcase

    response_d    = res;
    flgs_d        = 4'b0000;
    flgs_d[FLG_N] = res[LEN-1];
    flgs_d[FLG_Z] = (res == '0);
    flgs_d[FLG_C] = c_bit;
    flgs_d[FLG_V] = v_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      response_q <= '0;
      flgs_q     <= 4'b0000;
    end else begin
      response_q <= response_d;
      flgs_q     <= flgs_d;
    end
  end

  assign response = response_q;
  assign flgs     = flgs_q;

endmodule

// File: tb/tb_alu_main.sv
// Scoreboard bench for alu_main: expected results are queued when inputs are
// driven and compared one cycle later on the falling edge.
module tb_alu_main;

  localparam int LEN   = 32;
  localparam int SHIFT = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic            clk;
  logic            rst;
  logic [LEN-1:0]  response;
  logic [LEN-1:0]  a;
  logic [LEN-1:0]  b;
  logic [3:0]      opcd;
  logic [3:0]      flgs;

  int total;
  int bad;

  logic [LEN-1:0] exp_res_q[$];
  logic [3:0]     exp_flg_q[$];
  string          tag_q[$];

  alu_main #(.LEN(LEN), .SHIFT(SHIFT)) dut (
    .clk      (clk),
    .rst      (rst),
    .response (response),
    .a        (a),
    .b        (b),
    .opcd     (opcd),
    .flgs     (flgs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [3:0] op);
    logic [31:0] r;
    logic        c, v;
    logic [63:0] t;
    longint      sa, sb, sr;
    r  = ma;
    c  = 1'b0;
    v  = 1'b0;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (op)
      4'd0: begin
        t = 64'(ma) + 64'(mb);
        r = t[31:0];
        c = t[32];
        sr = sa + sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      4'd1: begin
        r = ma - mb;
        c = (ma >= mb);
        sr = sa - sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      4'd2: begin
        t = 64'(ma) * 64'(mb);
        r = t[31:0];
        c = (t[63:32] != 0);
        v = c;
      end
      4'd3: r = ma | mb;
      4'd4: r = ma & mb;
      4'd5: r = ma ^ mb;
      4'd6: begin
        t = 64'(ma) << SHIFT;
        r = t[31:0];
        c = t[32];
      end
      4'd7: begin
        t = {ma, 32'h0} >> SHIFT;
        r = t[63:32];
        c = t[31];
      end
      4'd8: begin
        t = {ma, 32'h0} >> SHIFT;
        r = t[63:32] | t[31:0];
        c = r[31];
      end
      default: r = ma;
    endcase
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

  // one cycle: compare the oldest pending result, then drive new inputs
  task automatic step(input string tag, input logic rv, input logic [31:0] av,
                      input logic [31:0] bv, input logic [3:0] ov,
                      input logic [31:0] er, input logic [3:0] ef);
    string t;
    @(negedge clk);
    if (exp_res_q.size() > 0) begin
      t = tag_q.pop_front();
      chk({t, ".res"}, response, exp_res_q.pop_front());
      chk({t, ".flg"}, {28'h0, flgs}, {28'h0, exp_flg_q.pop_front()});
    end
    rst  = rv;
    a    = av;
    b    = bv;
    opcd = ov;
    tag_q.push_back(tag);
    exp_res_q.push_back(er);
    exp_flg_q.push_back(ef);
  endtask

  task automatic step_model(input string tag, input logic [31:0] av,
                            input logic [31:0] bv, input logic [3:0] ov);
    logic [35:0] m;
    m = model(av, bv, ov);
    step(tag, 1'b0, av, bv, ov, m[31:0], m[35:32]);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a     = '0;
    b     = '0;
    opcd  = 4'd0;

    step("reset",     1'b1, 32'd2, 32'd2, 4'd0, 32'h0, 4'b0000);
    step("add_2_2",   1'b0, 32'd2, 32'd2, 4'd0, 32'h4, 4'b0000);
    step("add_carry", 1'b0, 32'hFFFFFFFF, 32'h10000000, 4'd0, 32'h0FFFFFFF, 4'b0010);
    step("add_ovf",   1'b0, 32'h7FFFFFFF, 32'h1, 4'd0, 32'h80000000, 4'b1001);
    step("add_wrap0", 1'b0, 32'hFFFFFFFF, 32'h1, 4'd0, 32'h0, 4'b0110);
    step("sub_7_6",   1'b0, 32'd7, 32'd6, 4'd1, 32'h1, 4'b0010);
    step("sub_6_7",   1'b0, 32'd6, 32'd7, 4'd1, 32'hFFFFFFFF, 4'b1000);
    step("sub_ovf",   1'b0, 32'h80000000, 32'h1, 4'd1, 32'h7FFFFFFF, 4'b0011);
    step("mul_3_2",   1'b0, 32'd3, 32'd2, 4'd2, 32'h6, 4'b0000);
    step("mul_hi",    1'b0, 32'h10000, 32'h10000, 4'd2, 32'h0, 4'b0111);
    step("or",        1'b0, 32'd7, 32'd3, 4'd3, 32'h7, 4'b0000);
    step("and",       1'b0, 32'd4, 32'd14, 4'd4, 32'h4, 4'b0000);
    step("xor",       1'b0, 32'd15, 32'd6, 4'd5, 32'h9, 4'b0000);
    step("and_zero",  1'b0, 32'hF0, 32'h0F, 4'd4, 32'h0, 4'b0100);
    step("lsl_3",     1'b0, 32'd3, 32'hDEAD, 4'd6, 32'hC, 4'b0000);
    step("lsl_out",   1'b0, 32'h40000000, 32'h0, 4'd6, 32'h0, 4'b0110);
    step("lsr_3",     1'b0, 32'd3, 32'h1234, 4'd7, 32'h0, 4'b0110);
    step("ror_2",     1'b0, 32'd2, 32'h0, 4'd8, 32'h80000000, 4'b1010);
    step("rsvd_12",   1'b0, 32'd5, 32'h77, 4'd12, 32'h5, 4'b0000);
    step("rst_mid",   1'b1, 32'd2, 32'd2, 4'd0, 32'h0, 4'b0000);
    step("post_rst",  1'b0, 32'd2, 32'd2, 4'd0, 32'h4, 4'b0000);

    for (int i = 0; i < 64; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  ro;
      ra = $urandom();
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom();
      ro = 4'(i % 16);
      step_model($sformatf("rnd%0d_op%0d", i, ro), ra, rb, ro);
    end

    // drain the last queued result
    @(negedge clk);
    if (exp_res_q.size() > 0) begin
      string t;
      t = tag_q.pop_front();
      chk({t, ".res"}, response, exp_res_q.pop_front());
      chk({t, ".flg"}, {28'h0, flgs}, {28'h0, exp_flg_q.pop_front()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
